// File: rtl/npu_job_ctrl_if.sv
// Bundle of the job-descriptor handshake, NPU issue/write-back and data-memory ports.
// master = CPU/NPU/memory side, slave = npu_job_ctrl.
interface npu_job_ctrl_if;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_a;
  logic [31:0] job_b;
  logic [31:0] job_c;

  logic        npu_en;
  logic [31:0] npu_get_data;
  logic        npu_pass_we;
  logic        npu_ack;
  logic [31:0] npu_modified_addr;
  logic [31:0] npu_modified_data;

  logic        cpu_mem_we;
  logic [31:0] cpu_mem_addr;
  logic [31:0] cpu_mem_wdata;
  logic        cpu_stall;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output job_valid, job_a, job_b, job_c,
    output npu_pass_we, npu_ack, npu_modified_addr, npu_modified_data,
    output cpu_mem_we, cpu_mem_addr, cpu_mem_wdata,
    input  job_ready, npu_en, npu_get_data, cpu_stall,
    input  mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  job_valid, job_a, job_b, job_c,
    input  npu_pass_we, npu_ack, npu_modified_addr, npu_modified_data,
    input  cpu_mem_we, cpu_mem_addr, cpu_mem_wdata,
    output job_ready, npu_en, npu_get_data, cpu_stall,
    output mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/npu_job_ctrl.sv
// Job sequencer and data-memory write arbiter for the 3x3 systolic NPU.
// Define NPU_TIMEOUT_EN to add the RUN-state watchdog, ABORT state and err_timeout.
module npu_job_ctrl #(
  parameter int JOB_DEPTH = 4,
  parameter int MAT_ELEMS = 9
`ifdef NPU_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic        clk,
  input  logic        rst,
  npu_job_ctrl_if.slave bus,
  output logic        busy,
  output logic        done,
  output logic [7:0]  job_count,
  output logic        err_misaligned,
  output logic        err_count,
  output logic        err_timeout
);
  localparam int AW = $clog2(JOB_DEPTH);

  typedef enum logic [2:0] {
    IDLE, ISSUE0, ISSUE1, ISSUE2, RUN, DONE
`ifdef NPU_TIMEOUT_EN
    , ABORT
`endif
  } state_t;

  state_t state, next_state;

  logic [31:0] fifo_a [JOB_DEPTH];
  logic [31:0] fifo_b [JOB_DEPTH];
  logic [31:0] fifo_c [JOB_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW-1:0] rd_idx;
  logic        empty, full, accept, misaligned, push, pop;
  logic [3:0]  wb_cnt;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty         = (wr_ptr == rd_ptr);
  assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_idx        = rd_ptr[AW-1:0];
  assign bus.job_ready = !full;
  assign accept        = bus.job_valid && !full;
  assign misaligned    = |{bus.job_a[1:0], bus.job_b[1:0], bus.job_c[1:0]};
  assign push          = accept && !misaligned;
  assign busy          = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr[AW-1:0]] <= bus.job_a;
      fifo_b[wr_ptr[AW-1:0]] <= bus.job_b;
      fifo_c[wr_ptr[AW-1:0]] <= bus.job_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

`ifdef NPU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] run_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      run_cnt <= (state == RUN) ? run_cnt + TW'(1) : '0;
      if (state == ABORT) err_timeout <= 1'b1;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    next_state       = state;
    bus.npu_en       = 1'b0;
    bus.npu_get_data = '0;
    done             = 1'b0;
    pop              = 1'b0;
    case (state)
      IDLE:   if (!empty) next_state = ISSUE0;
      ISSUE0: begin
        bus.npu_en       = 1'b1;
        bus.npu_get_data = fifo_a[rd_idx];
        next_state       = ISSUE1;
      end
      ISSUE1: begin
        bus.npu_en       = 1'b1;
        bus.npu_get_data = fifo_b[rd_idx];
        next_state       = ISSUE2;
      end
      ISSUE2: begin
        bus.npu_en       = 1'b1;
        bus.npu_get_data = fifo_c[rd_idx];
        next_state       = RUN;
      end
      RUN: begin
        bus.npu_en = 1'b1;
        if (bus.npu_ack) next_state = DONE;
`ifdef NPU_TIMEOUT_EN
        else if (run_cnt == TW'(TIMEOUT - 1)) next_state = ABORT;
`endif
      end
      // npu_en is low here so the NPU clears its internal counters between jobs.
      DONE: begin
        done       = 1'b1;
        pop        = 1'b1;
        next_state = IDLE;
      end
`ifdef NPU_TIMEOUT_EN
      ABORT: begin
        pop        = 1'b1;
        next_state = IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      wb_cnt         <= '0;
      job_count      <= '0;
      err_misaligned <= 1'b0;
      err_count      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (accept && misaligned) err_misaligned <= 1'b1;
      if (state == RUN && bus.npu_pass_we) wb_cnt <= wb_cnt + 4'd1;
      if (done) begin
        job_count <= job_count + 8'd1;
        if (wb_cnt != 4'(MAT_ELEMS)) err_count <= 1'b1;
      end
      if (pop) wb_cnt <= '0;
    end
  end

  // The NPU write-back always wins the memory port, in any state.
  always_comb begin
    bus.mem_we    = bus.cpu_mem_we;
    bus.mem_addr  = bus.cpu_mem_addr;
    bus.mem_wdata = bus.cpu_mem_wdata;
    bus.cpu_stall = 1'b0;
    if (bus.npu_pass_we) begin
      bus.mem_we    = 1'b1;
      bus.mem_addr  = bus.npu_modified_addr;
      bus.mem_wdata = bus.npu_modified_data;
      bus.cpu_stall = bus.cpu_mem_we;
    end
  end
endmodule

// File: tb/tb_npu_job_ctrl.sv
// Bench for npu_job_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based job model.
`timescale 1ns/1ps
module tb_npu_job_ctrl;
  localparam int JOB_DEPTH = 4;
  localparam int MAT_ELEMS = 9;
`ifdef NPU_TIMEOUT_EN
  localparam int TIMEOUT = 64;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy, done, err_misaligned, err_count, err_timeout;
  logic [7:0] job_count;

  npu_job_ctrl_if bus();

  npu_job_ctrl #(
    .JOB_DEPTH(JOB_DEPTH),
    .MAT_ELEMS(MAT_ELEMS)
`ifdef NPU_TIMEOUT_EN
    , .TIMEOUT(TIMEOUT)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy),
    .done(done),
    .job_count(job_count),
    .err_misaligned(err_misaligned),
    .err_count(err_count),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural job model ----------------
  typedef struct packed { logic [31:0] a, b, c; } job_t;
  job_t       m_q[$];
  int         m_pos = -1;   // cycles since current job's first issue word; -1 = nothing in flight
  bit         m_done_now = 0;
  bit         m_abort_now = 0;
  int         m_wb = 0;
  int         m_run = 0;
  logic [7:0] m_count = 0;
  bit         m_mis = 0, m_cerr = 0, m_terr = 0;
  bit         had_job, can_take;
  bit         model_on = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_pos = -1; m_done_now = 0; m_abort_now = 0;
      m_wb = 0; m_run = 0; m_count = 0;
      m_mis = 0; m_cerr = 0; m_terr = 0;
    end else begin
      had_job  = (m_q.size() != 0);
      can_take = (m_q.size() < JOB_DEPTH);
      if (m_done_now || m_abort_now) begin
        void'(m_q.pop_front());
        if (m_done_now) begin
          m_count = m_count + 8'd1;
          if ((m_wb % 16) != MAT_ELEMS) m_cerr = 1;
        end else begin
          m_terr = 1;
        end
        m_done_now = 0; m_abort_now = 0;
      end else if (m_pos >= 0) begin
        if (m_pos < 3) m_pos++;
        else begin
          if (bus.npu_pass_we) m_wb++;
          if (bus.npu_ack) begin m_done_now = 1; m_pos = -1; end
`ifdef NPU_TIMEOUT_EN
          else if (m_run == TIMEOUT - 1) begin m_abort_now = 1; m_pos = -1; end
          else m_run++;
`endif
        end
      end else if (had_job) begin
        m_pos = 0; m_wb = 0; m_run = 0;
      end
      if (bus.job_valid && can_take) begin
        if (bus.job_a[1:0] != 0 || bus.job_b[1:0] != 0 || bus.job_c[1:0] != 0) m_mis = 1;
        else m_q.push_back('{a: bus.job_a, b: bus.job_b, c: bus.job_c});
      end
    end
  end

  logic [31:0] e_data, e_addr, e_wdata;
  logic        e_we, e_stall;

  always @(negedge clk) begin
    if (model_on) begin
      e_data = 32'h0;
      if (m_pos == 0) e_data = m_q[0].a;
      if (m_pos == 1) e_data = m_q[0].b;
      if (m_pos == 2) e_data = m_q[0].c;
      if (bus.npu_pass_we) begin
        e_we = 1; e_addr = bus.npu_modified_addr; e_wdata = bus.npu_modified_data; e_stall = bus.cpu_mem_we;
      end else begin
        e_we = bus.cpu_mem_we; e_addr = bus.cpu_mem_addr; e_wdata = bus.cpu_mem_wdata; e_stall = 0;
      end
      checkOutput("npu_en", bus.npu_en, 32'(m_pos >= 0));
      checkOutput("npu_get_data", bus.npu_get_data, e_data);
      checkOutput("done", done, 32'(m_done_now));
      checkOutput("busy", busy, 32'(m_pos >= 0 || m_q.size() != 0));
      checkOutput("job_ready", bus.job_ready, 32'(m_q.size() < JOB_DEPTH));
      checkOutput("job_count", job_count, 32'(m_count));
      checkOutput("err_misaligned", err_misaligned, 32'(m_mis));
      checkOutput("err_count", err_count, 32'(m_cerr));
      checkOutput("err_timeout", err_timeout, 32'(m_terr));
      checkOutput("mem_we", bus.mem_we, 32'(e_we));
      checkOutput("mem_addr", bus.mem_addr, e_addr);
      checkOutput("mem_wdata", bus.mem_wdata, e_wdata);
      checkOutput("cpu_stall", bus.cpu_stall, 32'(e_stall));
    end
  end

  // ---------------- NPU responder ----------------
  int          npu_target = MAT_ELEMS;
  bit          npu_hold = 0, npu_gaps = 0, npu_stray = 0, npu_manual = 0;
  int          en_cnt = 0, npu_written = 0;
  logic [31:0] c_base = 0;

  initial begin
    bus.npu_pass_we = 0; bus.npu_ack = 0;
    bus.npu_modified_addr = 0; bus.npu_modified_data = 0;
    forever begin
      @(posedge clk); #1;
      if (bus.npu_en) en_cnt++;
      else begin en_cnt = 0; npu_written = 0; end
      if (!npu_manual) begin
        bus.npu_pass_we = 0; bus.npu_ack = 0;
        if (en_cnt == 3) c_base = bus.npu_get_data;
        if (en_cnt >= 4) begin
          if (npu_written < npu_target) begin
            if (!npu_gaps || $urandom_range(3) != 0) begin
              bus.npu_pass_we = 1;
              bus.npu_modified_addr = c_base + 32'(4 * npu_written);
              bus.npu_modified_data = $urandom;
              npu_written++;
            end
          end else if (!npu_hold) bus.npu_ack = 1;
        end else if (npu_stray) begin
          if ($urandom_range(15) == 0) begin
            bus.npu_pass_we = 1; bus.npu_modified_addr = $urandom; bus.npu_modified_data = $urandom;
          end
          if ($urandom_range(15) == 0) bus.npu_ack = 1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit seen_ready;

  task automatic applyStimulus(input bit valid, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                               input bit cwe, input logic [31:0] caddr, input logic [31:0] cdata);
    bus.job_valid = valid; bus.job_a = a; bus.job_b = b; bus.job_c = c;
    bus.cpu_mem_we = cwe; bus.cpu_mem_addr = caddr; bus.cpu_mem_wdata = cdata;
    @(negedge clk);
    seen_ready = bus.job_ready;
    @(posedge clk); #1;
  endtask

  task automatic idleInputs();
    bus.job_valid = 0; bus.job_a = 0; bus.job_b = 0; bus.job_c = 0;
    bus.cpu_mem_we = 0; bus.cpu_mem_addr = 0; bus.cpu_mem_wdata = 0;
  endtask

  task automatic pushJob(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, output bit first_ready);
    bit ok = 0;
    first_ready = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      applyStimulus(1'b1, a, b, c, 1'b0, 32'h0, 32'h0);
      if (t == 0) first_ready = seen_ready;
      ok = seen_ready;
    end
    idleInputs();
    checkOutput("push_accepted", 32'(ok), 32'h1);
  endtask

  task automatic waitJobCount(input logic [7:0] target, input int budget);
    bit hit = 0;
    for (int t = 0; t < budget && !hit; t++) begin
      @(negedge clk);
      hit = (job_count == target);
    end
    checkOutput("job_count_reached", 32'(job_count), 32'(target));
    @(posedge clk); #1;
  endtask

  bit          fr;
  bit          readies [5];
  logic [31:0] issued [3];
  int          n_issue, n_wb, n_done, first_en, en_cycles;

  initial begin
    idleInputs();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_on = 1;
    @(negedge clk);
    checkOutput("rst_job_ready", bus.job_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_job_count", job_count, 0);
    checkOutput("rst_errs", {err_misaligned, err_count, err_timeout}, 0);
    checkOutput("rst_npu_en", bus.npu_en, 0);
    checkOutput("rst_get_data", bus.npu_get_data, 0);
    @(posedge clk); #1;

    $display("[TB] single job A=0x00 B=0x24 C=0x48");
    pushJob(32'h00, 32'h24, 32'h48, fr);
    n_issue = 0; n_wb = 0; n_done = 0; first_en = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.npu_en && n_issue < 3) begin
        if (first_en < 0) first_en = i;
        issued[n_issue] = bus.npu_get_data;
        n_issue++;
      end
      if (bus.mem_we) begin
        checkOutput("wb_addr", bus.mem_addr, 32'h48 + 32'(4 * n_wb));
        n_wb++;
      end
      if (done) n_done++;
    end
    @(posedge clk); #1;
    checkOutput("issue_latency", 32'(first_en), 1);
    checkOutput("issue_a", issued[0], 32'h00);
    checkOutput("issue_b", issued[1], 32'h24);
    checkOutput("issue_c", issued[2], 32'h48);
    checkOutput("wb_writes", 32'(n_wb), 9);
    checkOutput("done_pulses", 32'(n_done), 1);
    checkOutput("job_count_1", job_count, 1);

    $display("[TB] misaligned descriptor");
    pushJob(32'h100, 32'h26, 32'h200, fr);
    @(negedge clk);
    checkOutput("mis_flag", err_misaligned, 1);
    checkOutput("mis_busy", busy, 0);
    @(posedge clk); #1;

    $display("[TB] arbiter priority");
    npu_manual = 1;
    @(posedge clk); #1;
    bus.npu_pass_we = 1; bus.npu_modified_addr = 32'h200; bus.npu_modified_data = 32'hBEEF;
    bus.cpu_mem_we = 1; bus.cpu_mem_addr = 32'h100; bus.cpu_mem_wdata = 32'hDEAD;
    @(negedge clk);
    checkOutput("arb_stall", bus.cpu_stall, 1);
    checkOutput("arb_npu_addr", bus.mem_addr, 32'h200);
    checkOutput("arb_npu_data", bus.mem_wdata, 32'hBEEF);
    @(posedge clk); #1;
    bus.npu_pass_we = 0;
    @(negedge clk);
    checkOutput("arb_nostall", bus.cpu_stall, 0);
    checkOutput("arb_cpu_we", bus.mem_we, 1);
    checkOutput("arb_cpu_addr", bus.mem_addr, 32'h100);
    checkOutput("arb_cpu_data", bus.mem_wdata, 32'hDEAD);
    @(posedge clk); #1;
    idleInputs();
    npu_manual = 0;

    $display("[TB] short write-back");
    npu_target = 8;
    pushJob(32'h300, 32'h324, 32'h348, fr);
    waitJobCount(8'd2, 60);
    checkOutput("short_err_count", err_count, 1);
    npu_target = MAT_ELEMS;

    $display("[TB] five jobs back-to-back");
    npu_hold = 1;
    for (int j = 0; j < 4; j++) begin
      pushJob(32'h1000 + 32'(j * 16'h100), 32'h2000 + 32'(j * 16'h100), 32'h3000 + 32'(j * 16'h100), fr);
      readies[j] = fr;
    end
    npu_hold = 0;
    pushJob(32'h1400, 32'h2400, 32'h3400, fr);
    readies[4] = fr;
    checkOutput("b2b_ready_pattern", {readies[0], readies[1], readies[2], readies[3], readies[4]}, 5'b11110);
    waitJobCount(8'd7, 400);

`ifdef NPU_TIMEOUT_EN
    $display("[TB] watchdog abort");
    npu_hold = 1;
    pushJob(32'h40, 32'h44, 32'h48, fr);
    en_cycles = 0; n_done = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (bus.npu_en) en_cycles++;
      if (done) n_done++;
    end
    @(posedge clk); #1;
    checkOutput("to_en_cycles", 32'(en_cycles), 32'(3 + TIMEOUT));
    checkOutput("to_err", err_timeout, 1);
    checkOutput("to_no_done", 32'(n_done), 0);
    checkOutput("to_job_count", job_count, 7);
    npu_hold = 0;
`endif

    $display("[TB] reset mid-run");
    npu_hold = 1;
    pushJob(32'h80, 32'h84, 32'h88, fr);
    repeat (6) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    checkOutput("mid_rst_npu_en", bus.npu_en, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_ready", bus.job_ready, 1);
    checkOutput("mid_rst_count", job_count, 0);
    @(posedge clk); #1;
    npu_hold = 0;

    $display("[TB] randomized traffic");
    npu_gaps = 1; npu_stray = 1;
    for (int i = 0; i < 3000; i++) begin
      if (!bus.npu_en) npu_target = $urandom_range(MAT_ELEMS + 1, MAT_ELEMS - 1);
      if ($urandom_range(499) == 0) rst = 1;
      applyStimulus($urandom_range(2) == 0,
                    {$urandom_range(32'hFFFF), ($urandom_range(15) == 0) ? 2'b10 : 2'b00},
                    {$urandom_range(32'hFFFF), 2'b00},
                    {$urandom_range(32'hFFFF), ($urandom_range(31) == 0) ? 2'b01 : 2'b00},
                    $urandom_range(1) == 1, $urandom, $urandom);
      rst = 0;
    end
    idleInputs();
    npu_stray = 0;
    repeat (200) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/npu_job_ctrl.md
# npu_job_ctrl

Job sequencer and memory-port arbiter for the 3×3 systolic NPU. Accepts matrix-multiply job descriptors (A, B, C base byte addresses) from the CPU into a small FIFO. Issues each job to the NPU by driving its enable and descriptor-word sequence, then forwards the NPU's result write-back onto the shared data-memory write port, stalling CPU stores while it does so. Reports completion and errors.

## Interface
- JOB_DEPTH, 4, descriptor FIFO entries (power of 2, ≥2)
- MAT_ELEMS, 9, result words written back per job
- TIMEOUT, 64, RUN-state cycle limit (used only with NPU_TIMEOUT_EN)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- job_valid  in  1  descriptor offered
- job_ready  out  1  FIFO not full; transfer when job_valid && job_ready
- job_a / job_b / job_c  in  32 each  byte base addresses of A, B, C
- busy  out  1  FSM not IDLE or FIFO non-empty
- done  out  1  one-cycle pulse per completed job
- job_count  out  8  completed jobs, wraps 255→0
- err_misaligned / err_count / err_timeout  out  1 each  sticky; cleared by rst only
- npu_en  out  1  NPU enable
- npu_get_data  out  32  descriptor word to NPU
- npu_pass_we / npu_ack  in  1 each  NPU write-back strobe / job-done
- npu_modified_addr / npu_modified_data  in  32 each  write-back address / data
- cpu_mem_we  in  1;  cpu_mem_addr / cpu_mem_wdata  in  32 each  CPU store request
- cpu_stall  out  1  CPU store not taken this cycle
- mem_we  out  1;  mem_addr / mem_wdata  out  32 each  data-memory write port

## Operation
- FIFO: push on job_valid && job_ready; any of job_a/b/c with bits[1:0]≠0 → handshake completes, entry discarded, err_misaligned set. Simultaneous push/pop when full is not allowed (job_ready=0 when full).
- FSM states: IDLE, ISSUE0, ISSUE1, ISSUE2, RUN, DONE (+ ABORT with NPU_TIMEOUT_EN).
- IDLE: FIFO non-empty → ISSUE0. npu_en=0, npu_get_data=0.
- ISSUE0/1/2: npu_en=1; npu_get_data = head.a / head.b / head.c respectively; advance one state per cycle.
- RUN: npu_en=1, npu_get_data=0. Each cycle with npu_pass_we increments wb_cnt (4 bit). npu_ack → DONE.
- DONE (1 cycle): npu_en=0 (forces NPU counter reset between jobs); pop FIFO; done=1; job_count+1; wb_cnt≠MAT_ELEMS → err_count set; wb_cnt cleared; → IDLE.
- Arbiter (combinational): npu_pass_we=1 → mem_* = {1, npu_modified_addr, npu_modified_data}, cpu_stall=cpu_mem_we. Otherwise mem_* = CPU request, cpu_stall=0. npu_pass_we outside RUN is still forwarded (NPU has priority unconditionally).
- npu_ack outside RUN ignored.

## Timing
- Reset values: job_ready=1 after the reset cycle; busy, done, job_count, err_*, npu_en, npu_get_data = 0; FIFO empty; FSM IDLE.
- Push to first ISSUE0 cycle: 2 cycles (push edge, IDLE sees non-empty next edge) when idle.
- ISSUE0 is the first npu_en=1 cycle; NPU latches A/B/C on en cycles 0/1/2.
- npu_ack cycle N → done pulse on cycle N+1; next job's ISSUE0 no earlier than N+3 (npu_en low ≥ 2 cycles).
- Back-to-back jobs: no bubble other than DONE+IDLE.
- rst mid-job: FSM, FIFO, counters, flags cleared on that edge; npu_en low next cycle; arbiter stays combinational (NPU write in flight still forwarded).

## Configuration
- NPU_TIMEOUT_EN defined: RUN counter from 0; reaching TIMEOUT without npu_ack → ABORT (1 cycle: npu_en=0, pop FIFO, err_timeout set, no done pulse, job_count unchanged) → IDLE.
- Undefined: no counter, no ABORT state; RUN waits for npu_ack indefinitely; err_timeout tied 0.

## Test plan
- Push {A=0x00,B=0x24,C=0x48} with NPU model doing 9 writes then ack → npu_get_data 0x00,0x24,0x48 on three consecutive npu_en cycles; mem sees 9 writes to 0x48..0x68; done=1 once, job_count=1.
- Push 5 jobs back-to-back with FIFO idle NPU stalled → job_ready falls after 4 (DONE not yet); all 5 eventually complete in order, job_count=5.
- CPU store 0x100←0xDEAD coincident with npu_pass_we → cpu_stall=1, mem takes NPU write; next cycle CPU store passes, cpu_stall=0.
- Push job_b=0x26 → accepted handshake, FIFO stays empty, err_misaligned=1, busy=0.
- NPU acks after only 8 writes → done pulses, err_count=1.
- NPU_TIMEOUT_EN, TIMEOUT=64, NPU never acks → npu_en drops 64 cycles after RUN entry, err_timeout=1, done never pulses; rst asserted mid-RUN in another run → npu_en=0 and FIFO empty next cycle.
